// File: rtl/draw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sequencer_if
//  Brief    : Client draw bus and VGA pixel bus seen by the draw sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface draw_sequencer_if;
    logic [3:0]  start;
    logic [3:0]  client_done;
    logic [35:0] client_x;
    logic [35:0] client_y;
    logic [11:0] client_colour;
    logic [8:0]  x_out;
    logic [8:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot;

    modport master (
        output start, x_out, y_out, colour_out, plot,
        input  client_done, client_x, client_y, client_colour
    );

    modport slave (
        input  start, x_out, y_out, colour_out, plot,
        output client_done, client_x, client_y, client_colour
    );
endinterface
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sequencer
//  Brief    : Per-frame round of up to four drawing clients onto one VGA port.
//             Optional macro TIMEOUT_EN adds a per-client RUN watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module draw_sequencer
`ifdef TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 4096
)
`endif
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic [3:0]             enable_mask,
    draw_sequencer_if.master       bus,
    output logic                   busy,
`ifdef TIMEOUT_EN
    output logic                   timeout_flag,
`endif
    output logic                   frame_done
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SELECT    = 3'd1;
    localparam logic [2:0] c_PRIME     = 3'd2;
    localparam logic [2:0] c_RUN       = 3'd3;
    localparam logic [2:0] c_GAP       = 3'd4;
    localparam logic [2:0] c_FRAME_END = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_mask;
    logic [1:0] r_idx;
    logic [3:0] w_avail;
    logic       w_sel_found;
    logic [1:0] w_sel_idx;
    logic       w_cur_done;
    logic       w_timeout;
    logic       w_plot_d;
    logic [5:0] w_xy_base;
    logic [5:0] w_col_base;

    // Remaining clients at or above the current index, lowest wins.
    assign w_avail     = r_mask & (4'b1111 << r_idx);
    assign w_sel_found = |w_avail;
    assign w_sel_idx   = w_avail[0] ? 2'd0 :
                         w_avail[1] ? 2'd1 :
                         w_avail[2] ? 2'd2 : 2'd3;
    assign w_cur_done  = bus.client_done[r_idx];
    assign w_xy_base   = {4'b0000, r_idx} * 6'd9;
    assign w_col_base  = {4'b0000, r_idx} * 6'd3;

`ifdef TIMEOUT_EN
    localparam logic [12:0] c_TO_LAST = 13'(TIMEOUT_CYCLES - 1);
    logic [12:0] r_cnt;

    assign w_timeout = (r_state == c_RUN) && !w_cur_done && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= 13'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (r_state == c_PRIME)
                r_cnt <= 13'd0;
            else if (r_state == c_RUN)
                r_cnt <= r_cnt + 13'd1;
            if (w_timeout)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (frame_tick) w_next = (enable_mask == 4'b0000) ? c_FRAME_END : c_SELECT;
            c_SELECT:    w_next = w_sel_found ? c_PRIME : c_FRAME_END;
            c_PRIME:     w_next = c_RUN;
            c_RUN:       if (w_cur_done || w_timeout) w_next = c_GAP;
            c_GAP:       w_next = c_SELECT;
            c_FRAME_END: w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.start = 4'b0000;
        busy      = (r_state != c_IDLE);
        w_plot_d  = 1'b0;
        case (r_state)
            c_PRIME: bus.start = 4'b0001 << r_idx;
            c_RUN: begin
                bus.start = 4'b0001 << r_idx;
                w_plot_d  = !w_cur_done && !w_timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mask         <= 4'b0000;
            r_idx          <= 2'd0;
            bus.x_out      <= 9'd0;
            bus.y_out      <= 9'd0;
            bus.colour_out <= 3'd0;
            bus.plot       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            bus.plot   <= w_plot_d;
            frame_done <= (r_state == c_FRAME_END);
            case (r_state)
                c_IDLE: begin
                    if (frame_tick) begin
                        r_mask <= enable_mask;
                        r_idx  <= 2'd0;
                    end
                end
                c_SELECT: if (w_sel_found) r_idx <= w_sel_idx;
                c_RUN: begin
                    bus.x_out      <= bus.client_x[w_xy_base +: 9];
                    bus.y_out      <= bus.client_y[w_xy_base +: 9];
                    bus.colour_out <= bus.client_colour[w_col_base +: 3];
                end
                c_GAP:   r_mask[r_idx] <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
